song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Playback engine directly downstream of the song memory: walks a song stored as one note entry per RAM word, starting at a base address.
- Issues word addresses to the RAM, captures read data after the fixed one-cycle RAM read latency, decodes each entry and holds the note code for its duration.
- Note code goes to the tone generator / buzzer stage; status goes to the mode controller and LEDs.

Parameters:
- ADDR_W, 14, RAM word-address width (matches RAM addra).
- DATA_W, 32, RAM data width (matches RAM douta).
- TICK_CYCLES, 12_500_000, clk cycles per duration unit (1/8 s at 100 MHz).
- GAP_CYCLES, 1_000_000, silent cycles inserted after every note (articulation).
- MAX_NOTES, 1024, entries scanned before forced termination.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback at song_base (ignored unless IDLE or DONE).
- stop  in  1  level; aborts playback, returns to IDLE next cycle.
- pause  in  1  level; freezes the duration and gap counters and the FSM.
- song_base  in  ADDR_W  first word address of the song; sampled on start.
- mem_addr  out  ADDR_W  word address to RAM addra.
- mem_rdata  in  DATA_W  RAM douta; valid one cycle after mem_addr is presented.
- note_code  out  4  current note: 0 rest, 1..7 do..si, 8..14 reserved (played as rest).
- octave  out  2  octave of current note: 0 low, 1 mid, 2 high, 3 treated as mid.
- note_valid  out  1  high while a non-rest note sounds.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  one-cycle pulse when playback ends normally.
- note_index  out  ADDR_W  offset of the current entry from song_base, for display.

Behaviour:
- Entry format (low bits of mem_rdata):
  - [3:0] note; 15 = end marker.
  - [5:4] octave.
  - [9:6] duration in ticks; 0 = end marker.
  - Upper bits are ignored.
- Reset values: mem_addr = 0, note_code = 0, octave = 0, note_valid = 0, busy = 0, done = 0, note_index = 0, all counters 0, state IDLE.
- FSM states:
  - IDLE: outputs silent. On start: mem_addr <= song_base, note_index <= 0, go to FETCH.
  - FETCH: address stable for 1 cycle. Go to WAIT.
  - WAIT: RAM latency cycle. Go to DECODE.
  - DECODE: register mem_rdata.
    - End marker: go to DONE.
    - Otherwise: load note_code, octave, duration count = dur*TICK_CYCLES-1; note_valid = (note 1..7); go to PLAY.
  - PLAY: count down to 0, then go to GAP with note_valid = 0 and note_code = 0; gap counter = GAP_CYCLES-1.
  - GAP: count down to 0, then:
    - if note_index+1 == MAX_NOTES: go to DONE;
    - else mem_addr +1 (wraps modulo 2^ADDR_W), note_index +1, go to FETCH.
  - DONE: done pulses exactly one cycle on entry, outputs silent, busy = 0. Remains in DONE until start.
- Latency: start to first note_valid = 4 cycles (FETCH, WAIT, DECODE, register).
- Per-note period = dur*TICK_CYCLES + GAP_CYCLES + 3 cycles.
- pause: only PLAY/GAP counters and FETCH/WAIT/DECODE advancement freeze. Outputs hold, including note_valid (the tone stage mutes on pause itself).
- stop has priority over pause and start. Stop in any state: next cycle IDLE with silent outputs, no done pulse.
- start while busy: ignored.
- start and stop in the same cycle: stop wins.
- Asynchronous reset mid-playback: immediate return to reset values.
- GAP_CYCLES = 0: GAP lasts exactly 1 cycle.

Optional Feature:
- Macro SONG_LOOP_EN.
- Defined: extra input loop_en (1 bit). On an end marker with loop_en = 1:
  - no done pulse, no entry to DONE;
  - mem_addr <= song_base, note_index <= 0, go to FETCH.
  - MAX_NOTES termination still asserts done.
- Not defined: port absent; end marker always goes to DONE.

Test Plan (TICK_CYCLES=4, GAP_CYCLES=2, RAM model with 1-cycle latency):
- song_base=0x010, entries {note3,oct1,dur2},{note5,oct2,dur1},{end} + start -> mem_addr 0x010, 0x011, 0x012; note_code 3 held 8 cycles, 2-cycle gap, then 5 held 4 cycles; first note_valid 4 cycles after start; single done pulse; busy low after.
- Rest entry {note0,dur3} -> note_valid=0 for 12 cycles, then next fetch; note_index increments.
- pause asserted for 10 cycles mid-PLAY of a dur2 note -> note held 18 cycles total; no address change while paused.
- stop during GAP -> IDLE next cycle, outputs 0, no done; subsequent start replays from song_base.
- MAX_NOTES=3 with no end marker -> exactly 3 notes played, then done; song_base=0x3FFF with ADDR_W=14 -> second fetch address 0x0000.
- SONG_LOOP_EN, loop_en=1, 2-note song -> after end marker, mem_addr returns to song_base, no done; deassert loop_en -> done at next end marker.

Source files
------------

// File: rtl/song_sequencer.sv
// Song playback sequencer: walks note entries in song RAM and holds each note for its duration.
// Optional looping on end marker is enabled with `define SONG_LOOP_EN (adds input loop_en).
module song_sequencer #(
    parameter int          ADDR_W      = 14,
    parameter int          DATA_W      = 32,
    parameter int unsigned TICK_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned MAX_NOTES   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
`ifdef SONG_LOOP_EN
    input  logic              loop_en,
`endif
    input  logic [ADDR_W-1:0] song_base,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        note_code,
    output logic [1:0]        octave,
    output logic              note_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    // A zero-length gap still spends one cycle in GAP.
    localparam logic [31:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base_q, base_next;
    logic [ADDR_W-1:0] addr_next, index_next;
    logic [3:0]        code_next;
    logic [1:0]        octave_next;
    logic              valid_next, done_next;
    logic [31:0]       cnt, cnt_next;

    logic [3:0]        ent_note;
    logic [1:0]        ent_oct;
    logic [3:0]        ent_dur;
    logic              ent_end;
    logic [31:0]       play_load;
    logic              last_note;
    logic              do_loop;
    logic              rdata_unused;

    assign ent_note  = mem_rdata[3:0];
    assign ent_oct   = mem_rdata[5:4];
    assign ent_dur   = mem_rdata[9:6];
    assign ent_end   = (ent_note == 4'hF) || (ent_dur == 4'h0);
    assign play_load = 32'(ent_dur) * TICK_CYCLES - 32'd1;
    assign last_note = (32'(note_index) + 32'd1) == MAX_NOTES;
    assign rdata_unused = ^mem_rdata[DATA_W-1:10];

`ifdef SONG_LOOP_EN
    assign do_loop = loop_en;
`else
    assign do_loop = 1'b0;
`endif

    assign busy = (state != S_IDLE) && (state != S_DONE);

    // State and output registers; everything returns to silent idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            base_q     <= '0;
            mem_addr   <= '0;
            note_index <= '0;
            note_code  <= '0;
            octave     <= '0;
            note_valid <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            base_q     <= base_next;
            mem_addr   <= addr_next;
            note_index <= index_next;
            note_code  <= code_next;
            octave     <= octave_next;
            note_valid <= valid_next;
            done       <= done_next;
            cnt        <= cnt_next;
        end
    end

    // Next-state and next-output logic; stop overrides everything at the end.
    always_comb begin
        state_next  = state;
        base_next   = base_q;
        addr_next   = mem_addr;
        index_next  = note_index;
        code_next   = note_code;
        octave_next = octave;
        valid_next  = note_valid;
        done_next   = 1'b0;
        cnt_next    = cnt;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_next  = song_base;
                    addr_next  = song_base;
                    index_next = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!pause) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!pause) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!pause) begin
                    if (ent_end && do_loop) begin
                        addr_next  = base_q;
                        index_next = '0;
                        state_next = S_FETCH;
                    end else if (ent_end) begin
                        code_next   = '0;
                        octave_next = '0;
                        valid_next  = 1'b0;
                        done_next   = 1'b1;
                        state_next  = S_DONE;
                    end else begin
                        code_next   = ent_note;
                        octave_next = ent_oct;
                        valid_next  = (ent_note >= 4'd1) && (ent_note <= 4'd7);
                        cnt_next    = play_load;
                        state_next  = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt == 32'd0) begin
                        code_next  = '0;
                        valid_next = 1'b0;
                        cnt_next   = GAP_LOAD;
                        state_next = S_GAP;
                    end else begin
                        cnt_next = cnt - 32'd1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt != 32'd0) begin
                        cnt_next = cnt - 32'd1;
                    end else if (last_note) begin
                        code_next   = '0;
                        octave_next = '0;
                        valid_next  = 1'b0;
                        done_next   = 1'b1;
                        state_next  = S_DONE;
                    end else begin
                        addr_next  = mem_addr + 1'b1;
                        index_next = note_index + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (stop) begin
            state_next  = S_IDLE;
            addr_next   = '0;
            index_next  = '0;
            code_next   = '0;
            octave_next = '0;
            valid_next  = 1'b0;
            done_next   = 1'b0;
            cnt_next    = '0;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: decode table, arithmetic trace model, and corner sequences.
// Small timing parameters keep every song to a few dozen cycles.
module tb_song_sequencer;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int TICK = 4;
    localparam int GAP  = 2;
    localparam int MAXN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
`ifdef SONG_LOOP_EN
    logic          loop_en = 1'b0;
`endif
    logic [AW-1:0] song_base = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [3:0]    note_code;
    logic [1:0]    octave;
    logic          note_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] note_index;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    code;
        logic [1:0]    oct;
        logic          nv;
        logic          bsy;
        logic          dn;
        logic [AW-1:0] idx;
    } obs_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  code;
        logic [1:0]  oct;
        logic        nv;
        logic        is_end;
    } vec_t;

    obs_t exp_q[$];

    song_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .TICK_CYCLES(TICK),
        .GAP_CYCLES(GAP), .MAX_NOTES(MAXN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .pause(pause),
`ifdef SONG_LOOP_EN
        .loop_en(loop_en),
`endif
        .song_base(song_base), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .note_code(note_code),
        .octave(octave), .note_valid(note_valid), .busy(busy),
        .done(done), .note_index(note_index)
    );

    always #5 clk = ~clk;

    // Song RAM with one-cycle read latency.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    function automatic logic [31:0] mk(input int n, input int o,
                                       input int d, input logic [21:0] up);
        logic [3:0] nn;
        logic [1:0] oo;
        logic [3:0] dd;
        nn = n[3:0];
        oo = o[1:0];
        dd = d[3:0];
        return {up, dd, oo, nn};
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.addr = mem_addr;
        s.code = note_code;
        s.oct  = octave;
        s.nv   = note_valid;
        s.bsy  = busy;
        s.dn   = done;
        s.idx  = note_index;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic obs_t mko(input logic [AW-1:0] a, input int c,
                                 input int o, input bit nv, input bit b,
                                 input bit d, input logic [AW-1:0] i);
        obs_t s;
        logic [3:0] cc;
        logic [1:0] oo;
        cc = c[3:0];
        oo = o[1:0];
        s.addr = a; s.code = cc; s.oct = oo; s.nv = nv;
        s.bsy = b; s.dn = d; s.idx = i;
        return s;
    endfunction

    // Expected per-cycle outputs after a start, from the song rules:
    // 3 cycles fetch/wait/decode, dur*TICK play cycles, GAP silent cycles.
    task automatic build(input logic [AW-1:0] base);
        int i = 0;
        int oct = 0;
        logic [AW-1:0] a;
        logic [31:0] w;
        int n, d;
        exp_q.delete();
        forever begin
            a = base + AW'(i);
            w = mem[a];
            n = int'(w[3:0]);
            d = int'(w[9:6]);
            repeat (3) exp_q.push_back(mko(a, 0, oct, 0, 1, 0, AW'(i)));
            if (n == 15 || d == 0) begin
                exp_q.push_back(mko(a, 0, 0, 0, 0, 1, AW'(i)));
                exp_q.push_back(mko(a, 0, 0, 0, 0, 0, AW'(i)));
                break;
            end
            oct = int'(w[5:4]);
            repeat (d * TICK)
                exp_q.push_back(mko(a, n, oct, (n >= 1 && n <= 7), 1, 0, AW'(i)));
            repeat (GAP) exp_q.push_back(mko(a, 0, oct, 0, 1, 0, AW'(i)));
            if (i + 1 == MAXN) begin
                exp_q.push_back(mko(a, 0, 0, 0, 0, 1, AW'(i)));
                exp_q.push_back(mko(a, 0, 0, 0, 0, 0, AW'(i)));
                break;
            end
            i++;
        end
    endtask

    task automatic run_trace(input string tag, input logic [AW-1:0] base);
        build(base);
        @(negedge clk);
        song_base = base;
        start = 1'b1;
        foreach (exp_q[k]) begin
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("%s_c%0d", tag, k), 64'(sample()), 64'(exp_q[k]));
        end
    endtask

    task automatic go_idle();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic pause_test();
        int nv_cnt = 0;
        int pc = 0;
        bit pd = 0;
        bit addr_bad = 0;
        bit seen_done = 0;
        logic [AW-1:0] a0 = '0;
        mem[14'h080] = mk(2, 1, 2, 22'h0);
        mem[14'h081] = 32'h0;
        @(negedge clk); song_base = 14'h080; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(posedge clk); #1;
            if (note_valid) nv_cnt++;
            if (done) seen_done = 1;
            if (pause) begin
                pc++;
                if (mem_addr !== a0) addr_bad = 1;
                if (pc == 10) pause = 1'b0;
            end else if (!pd && nv_cnt == 3) begin
                pause = 1'b1;
                pd = 1;
                a0 = mem_addr;
            end
        end
        pause = 1'b0;
        check("pause_note_cycles", 64'(nv_cnt), 64'd18);
        check("pause_addr_hold", 64'(addr_bad), 64'd0);
        check("pause_done", 64'(seen_done), 64'd1);
    endtask

    task automatic stop_gap_test();
        bit was_nv = 0;
        bit found = 0;
        bit bad = 0;
        mem[14'h010] = mk(3, 1, 2, 22'h0);
        mem[14'h011] = mk(5, 2, 1, 22'h0);
        mem[14'h012] = 32'h0;
        @(negedge clk); song_base = 14'h010; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (was_nv && !note_valid) begin
                found = 1;
                break;
            end
            was_nv = note_valid;
        end
        check("stop_reach_gap", 64'(found), 64'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_outputs", 64'(sample()), 64'd0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) bad = 1;
        end
        check("stop_stays_idle", 64'(bad), 64'd0);
        run_trace("replay", 14'h010);
    endtask

`ifdef SONG_LOOP_EN
    task automatic loop_test();
        bit saw_end = 0;
        bit looped = 0;
        bit bad_done = 0;
        bit fin = 0;
        mem[14'h200] = mk(1, 1, 1, 22'h0);
        mem[14'h201] = mk(2, 1, 1, 22'h0);
        mem[14'h202] = 32'h0;
        loop_en = 1'b1;
        @(negedge clk); song_base = 14'h200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && !looped; c++) begin
            @(posedge clk); #1;
            if (done) bad_done = 1;
            if (mem_addr == 14'h202) saw_end = 1;
            if (saw_end && mem_addr == 14'h200 && note_index == '0) looped = 1;
        end
        check("loop_restart", 64'(looped), 64'd1);
        check("loop_no_done", 64'(bad_done), 64'd0);
        loop_en = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(posedge clk); #1;
            if (done) fin = 1;
        end
        check("loop_off_done", 64'(fin), 64'd1);
    endtask
`endif

    initial begin
        vec_t vt[8];
        logic [AW-1:0] rb;
        vt[0] = '{mk(3, 1, 2, 22'h0),      4'd3,  2'd1, 1'b1, 1'b0};
        vt[1] = '{mk(7, 2, 15, 22'h3FFFFF), 4'd7, 2'd2, 1'b1, 1'b0};
        vt[2] = '{mk(0, 0, 3, 22'h0),      4'd0,  2'd0, 1'b0, 1'b0};
        vt[3] = '{mk(9, 3, 1, 22'h1234),   4'd9,  2'd3, 1'b0, 1'b0};
        vt[4] = '{mk(14, 0, 4, 22'h0),     4'd14, 2'd0, 1'b0, 1'b0};
        vt[5] = '{mk(15, 1, 5, 22'h0),     4'd0,  2'd0, 1'b0, 1'b1};
        vt[6] = '{mk(2, 1, 0, 22'h0),      4'd0,  2'd0, 1'b0, 1'b1};
        vt[7] = '{mk(1, 3, 1, 22'h2AAAA),  4'd1,  2'd3, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(sample()), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 64'(sample()), 64'd0);

        foreach (vt[v]) begin
            mem[14'h100] = vt[v].word;
            mem[14'h101] = 32'h0;
            @(negedge clk); song_base = 14'h100; start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            if (vt[v].is_end)
                check($sformatf("vec%0d_end", v), 64'({done, busy}), 64'b10);
            else
                check($sformatf("vec%0d", v),
                      64'({note_code, octave, note_valid, busy}),
                      64'({vt[v].code, vt[v].oct, vt[v].nv, 1'b1}));
            go_idle();
        end

        mem[14'h010] = mk(3, 1, 2, 22'h0);
        mem[14'h011] = mk(5, 2, 1, 22'h0);
        mem[14'h012] = 32'h0;
        run_trace("basic", 14'h010);

        mem[14'h040] = mk(0, 0, 3, 22'h0);
        mem[14'h041] = mk(1, 0, 1, 22'h0);
        mem[14'h042] = 32'h0;
        run_trace("rest", 14'h040);

        pause_test();
        stop_gap_test();

        mem[14'h3FFF] = mk(1, 0, 1, 22'h0);
        mem[14'h0000] = mk(2, 1, 1, 22'h0);
        mem[14'h0001] = mk(3, 2, 1, 22'h0);
        mem[14'h0002] = mk(4, 0, 1, 22'h0);
        run_trace("wrap_max", 14'h3FFF);

        for (int s = 0; s < 20; s++) begin
            rb = AW'($urandom_range(0, (1 << AW) - 1));
            for (int k = 0; k < 4; k++) begin
                logic [AW-1:0] a;
                a = rb + AW'(k);
                if ($urandom_range(0, 6) == 0)
                    mem[a] = ($urandom_range(0, 1) == 0)
                           ? mk(15, 0, $urandom_range(1, 3), 22'($urandom))
                           : mk($urandom_range(0, 14), 0, 0, 22'($urandom));
                else
                    mem[a] = mk($urandom_range(0, 14), $urandom_range(0, 3),
                                $urandom_range(1, 3), 22'($urandom));
            end
            run_trace($sformatf("rnd%0d", s), rb);
        end

`ifdef SONG_LOOP_EN
        go_idle();
        loop_test();
`endif

        go_idle();
        mem[14'h010] = mk(3, 1, 2, 22'h0);
        @(negedge clk); song_base = 14'h010; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("async_reset", 64'(sample()), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
